// File: rtl/mips_mem_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encoding, port IDs
// and the legal range of the memory read latency.
package mips_mem_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RD_RESP = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int unsigned RD_LAT_MIN = 32'd1;
  localparam int unsigned RD_LAT_MAX = 32'd4;
  localparam int unsigned CNT_W      = 32'd3;

  // Out-of-range latencies are pinned to the nearest legal value.
  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < RD_LAT_MIN) begin
      return RD_LAT_MIN;
    end else if (lat > RD_LAT_MAX) begin
      return RD_LAT_MAX;
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; last_r remembers the port of the most
// recent grant so the other port wins the next tie.
module rr_arb2
  import mips_mem_pkg::*;
(
  input  logic       cclk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic       last_r;
  logic [1:0] gnt_s;

  // Pick the winner among the active requesters
  always_comb begin
    gnt_s = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (last_r == PORT_DMA) ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Track the port of every grant
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      last_r <= PORT_DMA;
    end else if (|gnt_s) begin
      last_r <= gnt_s[1];
    end else begin
      last_r <= last_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified memory between the CPU and DMA ports,
// one grant per cycle, and steers each read response back to its issuer.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32'd32,
  parameter int unsigned DATA_W = 32'd32,
  parameter int unsigned RD_LAT = 32'd1
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LAT_C = clamp_lat(RD_LAT);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             owner_r;
  logic [1:0]       gnt_s;
  logic             allow_s;
  logic             rvalid_s;

  // Reset gates the grant path so outputs fall the instant rst rises
  assign allow_s = !rst && (state_r != RD_WAIT);

  rr_arb2 u_rr_arb2 (
    .cclk (cclk),
    .rst  (rst),
    .en   (allow_s),
    .req  ({dma_req, cpu_req}),
    .gnt  (gnt_s)
  );

  // Winner mux onto the memory port and response steering to the owner
  always_comb begin
    cpu_gnt  = gnt_s[0];
    dma_gnt  = gnt_s[1];
    mem_en   = |gnt_s;
    rvalid_s = (state_r == RD_RESP);
    if (gnt_s[1]) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (gnt_s[0]) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
    cpu_rvalid = rvalid_s && (owner_r == PORT_CPU);
    dma_rvalid = rvalid_s && (owner_r == PORT_DMA);
    cpu_rdata  = cpu_rvalid ? mem_rdata : {DATA_W{1'b0}};
    dma_rdata  = dma_rvalid ? mem_rdata : {DATA_W{1'b0}};
  end

  // Read-latency tracker; a read grant in RD_RESP simply reloads it
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      owner_r <= PORT_CPU;
    end else if (mem_en && !mem_we) begin
      owner_r <= gnt_s[1];
      cnt_r   <= CNT_W'(LAT_C);
      state_r <= (LAT_C == 32'd1) ? RD_RESP : RD_WAIT;
    end else begin
      owner_r <= owner_r;
      case (state_r)
        RD_WAIT: begin
          cnt_r   <= cnt_r - CNT_W'(1);
          state_r <= (cnt_r == CNT_W'(2)) ? RD_RESP : RD_WAIT;
        end
        RD_RESP: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= IDLE;
        end
        IDLE: begin
          cnt_r   <= cnt_r;
          state_r <= IDLE;
        end
        default: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: four arbiters with RD_LAT 1..4 share one clock; read
// expectations are queued with their due cycle and checked by a monitor.
module tb_mem_arbiter;

  localparam int N = 4;

  logic        cclk = 1'b0;
  logic        rst;
  logic        cpu_req [N];
  logic        cpu_we [N];
  logic [31:0] cpu_addr [N];
  logic [31:0] cpu_wdata [N];
  logic        cpu_gnt [N];
  logic        cpu_rvalid [N];
  logic [31:0] cpu_rdata [N];
  logic        dma_req [N];
  logic        dma_we [N];
  logic [31:0] dma_addr [N];
  logic [31:0] dma_wdata [N];
  logic        dma_gnt [N];
  logic        dma_rvalid [N];
  logic [31:0] dma_rdata [N];
  logic        mem_en [N];
  logic        mem_we [N];
  logic [31:0] mem_addr [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic [31:0] pipe [N][4];

  typedef struct {
    int          inst;
    bit          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #10 cclk = ~cclk;

  always @(posedge cclk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g + 1)) u_dut (
      .cclk       (cclk),
      .rst        (rst),
      .cpu_req    (cpu_req[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_gnt    (cpu_gnt[g]),
      .cpu_rvalid (cpu_rvalid[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .dma_req    (dma_req[g]),
      .dma_we     (dma_we[g]),
      .dma_addr   (dma_addr[g]),
      .dma_wdata  (dma_wdata[g]),
      .dma_gnt    (dma_gnt[g]),
      .dma_rvalid (dma_rvalid[g]),
      .dma_rdata  (dma_rdata[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g])
    );
    assign mem_rdata[g] = pipe[g][g];
  end

  function automatic logic [31:0] rdfun(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (32'hA500_0000 | a);
  endfunction

  // Memory model: read data emerges RD_LAT cycles after the strobe
  always @(posedge cclk) begin
    for (int k = 0; k < N; k++) begin
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? rdfun(mem_addr[k]) : 32'h0;
      for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int k, input bit p, input logic [31:0] d);
    exp_t e;
    e.inst = k;
    e.port = p;
    e.data = d;
    e.due  = cyc + k + 1;
    sb.push_back(e);
  endtask

  // Monitor: every rvalid must match a queued expectation due this cycle
  always @(negedge cclk) begin
    logic        v;
    logic [31:0] d;
    int          idx;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < 2; p++) begin
        v   = (p == 1) ? dma_rvalid[k] : cpu_rvalid[k];
        d   = (p == 1) ? dma_rdata[k] : cpu_rdata[k];
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].inst == k && sb[i].port == p[0] && sb[i].due == cyc) idx = i;
        if (idx >= 0) begin
          chk($sformatf("rvalid[%0d].%0d", k, p), {31'd0, v}, 32'd1);
          chk($sformatf("rdata[%0d].%0d", k, p), d, sb[idx].data);
          sb.delete(idx);
        end else begin
          chk($sformatf("rvalid_idle[%0d].%0d", k, p), {31'd0, v}, 32'd0);
          chk($sformatf("rdata_idle[%0d].%0d", k, p), d, 32'd0);
        end
      end
    end
  end

  task automatic idle_all;
    for (int k = 0; k < N; k++) begin
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = 32'h0; cpu_wdata[k] = 32'h0;
      dma_req[k] = 1'b0; dma_we[k] = 1'b0; dma_addr[k] = 32'h0; dma_wdata[k] = 32'h0;
    end
  endtask

  task automatic tick;
    @(posedge cclk);
    #1;
  endtask

  task automatic mid;
    #3;
  endtask

  task automatic chk_quiet(input string nm, input int k);
    chk({nm, "_cgnt"}, {31'd0, cpu_gnt[k]}, 32'd0);
    chk({nm, "_dgnt"}, {31'd0, dma_gnt[k]}, 32'd0);
    chk({nm, "_en"}, {31'd0, mem_en[k]}, 32'd0);
    chk({nm, "_we"}, {31'd0, mem_we[k]}, 32'd0);
    chk({nm, "_addr"}, mem_addr[k], 32'd0);
    chk({nm, "_wdata"}, mem_wdata[k], 32'd0);
    chk({nm, "_crv"}, {31'd0, cpu_rvalid[k]}, 32'd0);
    chk({nm, "_drv"}, {31'd0, dma_rvalid[k]}, 32'd0);
    chk({nm, "_crd"}, cpu_rdata[k], 32'd0);
    chk({nm, "_drd"}, dma_rdata[k], 32'd0);
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    b2b_addr = '{32'h0, 32'h4, 32'h8};
    b2b_data = '{32'hA500_0000, 32'hA500_0004, 32'hA500_0008};

    // Reset with every port requesting: everything must stay quiet
    rst = 1'b1;
    idle_all();
    for (int k = 0; k < N; k++) begin
      cpu_req[k] = 1'b1; dma_req[k] = 1'b1; cpu_addr[k] = 32'h10; dma_addr[k] = 32'h20;
    end
    #2;
    for (int k = 0; k < N; k++) chk_quiet($sformatf("reset%0d", k), k);
    idle_all();
    #10 rst = 1'b0;
    tick();

    // Continuous write contention on LAT1 instance: CPU, DMA, CPU, DMA
    for (int i = 0; i < 4; i++) begin
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h100; cpu_wdata[0] = 32'h1111_0000 + i;
      dma_req[0] = 1'b1; dma_we[0] = 1'b1; dma_addr[0] = 32'h200; dma_wdata[0] = 32'h2222_0000 + i;
      mid();
      chk($sformatf("wr_cgnt%0d", i), {31'd0, cpu_gnt[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("wr_dgnt%0d", i), {31'd0, dma_gnt[0]}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("wr_addr%0d", i), mem_addr[0], (i % 2 == 0) ? 32'h100 : 32'h200);
      chk($sformatf("wr_wdata%0d", i), mem_wdata[0],
          (i % 2 == 0) ? (32'h1111_0000 + i) : (32'h2222_0000 + i));
      chk($sformatf("wr_we%0d", i), {31'd0, mem_we[0]}, 32'd1);
      tick();
    end
    idle_all();

    // CPU read on LAT2 instance, held request blocked during RD_WAIT
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h40;
    mid();
    chk("rd2_gnt", {31'd0, cpu_gnt[1]}, 32'd1);
    chk("rd2_en", {31'd0, mem_en[1]}, 32'd1);
    chk("rd2_addr", mem_addr[1], 32'h40);
    push_exp(1, 1'b0, 32'hDEADBEEF);
    tick();
    cpu_addr[1] = 32'h44;
    mid();
    chk("rd2_wait_gnt", {31'd0, cpu_gnt[1]}, 32'd0);
    chk("rd2_wait_en", {31'd0, mem_en[1]}, 32'd0);
    tick();
    cpu_req[1] = 1'b0;
    tick();
    tick();

    // DMA read pending on LAT3 instance while CPU waits, granted in RD_RESP
    dma_req[2] = 1'b1; dma_we[2] = 1'b0; dma_addr[2] = 32'h300;
    mid();
    chk("rd3_dgnt", {31'd0, dma_gnt[2]}, 32'd1);
    push_exp(2, 1'b1, 32'hA500_0300);
    tick();
    dma_req[2] = 1'b0;
    cpu_req[2] = 1'b1; cpu_we[2] = 1'b0; cpu_addr[2] = 32'h8;
    mid();
    chk("rd3_cgnt_w1", {31'd0, cpu_gnt[2]}, 32'd0);
    chk("rd3_en_w1", {31'd0, mem_en[2]}, 32'd0);
    tick();
    mid();
    chk("rd3_cgnt_w2", {31'd0, cpu_gnt[2]}, 32'd0);
    tick();
    mid();
    chk("rd3_cgnt_resp", {31'd0, cpu_gnt[2]}, 32'd1);
    chk("rd3_addr_resp", mem_addr[2], 32'h8);
    push_exp(2, 1'b0, 32'hA500_0008);
    tick();
    cpu_req[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back CPU reads on LAT1 instance
    for (int i = 0; i < 3; i++) begin
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = b2b_addr[i];
      mid();
      chk($sformatf("b2b_gnt%0d", i), {31'd0, cpu_gnt[0]}, 32'd1);
      chk($sformatf("b2b_addr%0d", i), mem_addr[0], b2b_addr[i]);
      push_exp(0, 1'b0, b2b_data[i]);
      tick();
    end
    cpu_req[0] = 1'b0;
    tick();
    tick();

    // Reset pulse mid-cycle while a DMA read is pending on LAT4 instance
    dma_req[3] = 1'b1; dma_we[3] = 1'b0; dma_addr[3] = 32'h600;
    mid();
    chk("rst_dgnt", {31'd0, dma_gnt[3]}, 32'd1);
    tick();
    dma_req[3] = 1'b0;
    cpu_req[3] = 1'b1; cpu_we[3] = 1'b1; cpu_addr[3] = 32'h700; cpu_wdata[3] = 32'h77;
    mid();
    chk("rst_cgnt_blk", {31'd0, cpu_gnt[3]}, 32'd0);
    tick();
    dma_req[3] = 1'b1; dma_we[3] = 1'b1; dma_addr[3] = 32'h800; dma_wdata[3] = 32'h88;
    #4 rst = 1'b1;
    #1;
    chk_quiet("rstpulse", 3);
    sb.delete();
    #2 rst = 1'b0;
    #1;
    chk("rst_tie_cgnt", {31'd0, cpu_gnt[3]}, 32'd1);
    chk("rst_tie_dgnt", {31'd0, dma_gnt[3]}, 32'd0);
    chk("rst_tie_addr", mem_addr[3], 32'h700);
    tick();
    cpu_req[3] = 1'b0;
    mid();
    chk("rst_next_dgnt", {31'd0, dma_gnt[3]}, 32'd1);
    chk("rst_next_addr", mem_addr[3], 32'h800);
    tick();
    idle_all();
    for (int i = 0; i < 6; i++) tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported unified instruction/data memory of the multicycle MIPS core between the core's memory interface (fetch, load and store) and a DMA/program-loader port. It grants one transaction per cycle with round-robin resolution on contention. It tracks the single outstanding read through the fixed memory read latency and routes the returned data to the requester that issued it. It sits between `control_unit`/datapath memory signals and the memory macro.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `RD_LAT`, 1, memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1–4.

Ports:
- `cclk` in 1, the single clock; all state updates on its rising edge.
- `rst` in 1, reset; asynchronous and active-high.
- `cpu_req` in 1, CPU request.
- `cpu_we` in 1, CPU write enable.
- `cpu_addr` in ADDR_W, CPU address.
- `cpu_wdata` in DATA_W, CPU write data.
- `cpu_gnt` out 1, CPU request accepted this cycle.
- `cpu_rvalid` out 1, CPU read data valid.
- `cpu_rdata` out DATA_W, CPU read data.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: identical set for the DMA port.
- `mem_en` out 1, memory access strobe.
- `mem_we` out 1, memory write strobe.
- `mem_addr` out ADDR_W, memory address.
- `mem_wdata` out DATA_W, memory write data.
- `mem_rdata` in DATA_W, memory read data.

## Operation
- States: `IDLE` (no read pending), `RD_WAIT` (read pending, cnt>1), `RD_RESP` (cnt==1, data returning).
- Grants are allowed in `IDLE` and `RD_RESP`. Grants are blocked in `RD_WAIT`: both `gnt` are 0 and `mem_en` is 0.
- A grant is combinational. In a grant-allowed cycle with any `req` high:
  - `mem_en`=1 and the winner's `gnt`=1.
  - `mem_we`/`mem_addr`/`mem_wdata` carry the winner's inputs.
- Non-granted requesters hold `req` and their inputs until `gnt`. Dropping `req` before `gnt` is legal and has no effect.
- Round-robin: a 1-bit `last` register records the port of every grant. When both ports request, the port that is not `last` wins. A single requester always wins.
- Write grant: the transaction completes in the grant cycle. The state is unchanged unless it was `RD_RESP`, in which case it goes to `IDLE`.
- Read grant:
  - `owner` is set to the winner and `cnt` to `RD_LAT`.
  - Next state is `RD_RESP` if `RD_LAT`==1, else `RD_WAIT`.
- Each cycle in `RD_WAIT`, `cnt` decrements. When it reaches 1 the state is `RD_RESP`.
- In `RD_RESP`:
  - `<owner>_rvalid`=1 and `<owner>_rdata`=`mem_rdata`.
  - The other port's rdata reads 0, and both rdata read 0 whenever rvalid is low.
  - A new grant in the same cycle is permitted and reloads `owner`/`cnt`.
- Throughput: one access per cycle for writes and for reads with `RD_LAT`=1. Reads with `RD_LAT`=N sustain one per N cycles.

## Timing
- Reset values (async, immediate):
  - State `IDLE`, `cnt`=0, `owner`=CPU.
  - `last`=DMA, so the CPU wins the first tie.
  - All `gnt`, `rvalid` and `mem_*` strobes are 0; rdata outputs are 0.
- Read latency: a grant in cycle t gives `rvalid` in cycle t+`RD_LAT`, exactly one cycle wide.
- Reset asserted while a read is pending: the read is abandoned, no `rvalid` is ever produced for it, and late `mem_rdata` is ignored.
- Simultaneous response and new request in `RD_RESP`: the response goes to the old owner and the grant to the arbitration winner, in the same cycle, with no conflict.
- A request during `RD_WAIT` is held and granted in the `RD_RESP` cycle at the earliest.

## Structure
- Shared package `mips_mem_pkg`:
  - state encoding (`IDLE`/`RD_WAIT`/`RD_RESP`);
  - port IDs (`PORT_CPU`=0, `PORT_DMA`=1);
  - `RD_LAT` legal-range constants.
- One sub-module, `rr_arb2`: a 2-requester round-robin picker with `last`-pointer register. Inputs: `req[1:0]` and `en`. Outputs: one-hot `gnt[1:0]`.
- Latency counter, owner register and muxes stay in `mem_arbiter`.

## Test plan
- CPU-only read, `RD_LAT`=2, `cpu_addr`=0x40, `mem_rdata`=0xDEADBEEF:
  - `cpu_gnt` and `mem_en` in cycle t;
  - no grant in t+1;
  - `cpu_rvalid`=1 with `cpu_rdata`=0xDEADBEEF in t+2;
  - `dma_rvalid`=0 throughout.
- Both ports request writes continuously from reset:
  - grants alternate CPU, DMA, CPU, DMA one per cycle;
  - `mem_addr` follows the winner each cycle.
- DMA read pending (`RD_LAT`=3) while the CPU requests:
  - `cpu_gnt` stays 0 for two cycles;
  - in the cycle `dma_rvalid`=1, `cpu_gnt`=1 in the same cycle.
- Back-to-back CPU reads, `RD_LAT`=1, addresses 0x0/0x4/0x8:
  - three consecutive grants;
  - `cpu_rvalid` high for three consecutive cycles with matching data.
- `rst` pulsed mid-cycle while a DMA read is pending with `RD_LAT`=4:
  - all outputs drop to 0 immediately;
  - no `dma_rvalid` afterwards;
  - the first subsequent tie goes to the CPU.
